vga_core: RTL and testbench

- Free-running 640x480 @ 60 Hz VGA timing generator with a built-in colour-bar test pattern.
- Driven directly by the pixel clock (nominal 25.175 MHz; 25 MHz acceptable).
- Produces 4-bit-per-channel RGB as individual bit outputs, plus HSYNC and VSYNC.
- Top-level leaf feeding the board's resistor-DAC VGA connector.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_pattern.sv | 33 +++
 rtl/vga_core.sv | 119 +++++++++++
 tb/tb_vga_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, counter width and pixel colour type
// for the 640x480 @ 60 Hz VGA timing generator.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = 800;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = 525;

   localparam int CNT_W     = 10;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern: combinational colour-bar generator. Eight 80-pixel bars;
// bar index bits 2/1/0 drive red/green/blue fully on. Black outside the
// active area.
module vga_pattern
   import vga_pkg::*;
#(
   parameter int V_VIS = V_VISIBLE
) (
   input  logic [CNT_W-1:0] count_h,
   input  logic [CNT_W-1:0] count_v,
   input  logic             active,
   output rgb12_t           rgb
);

   logic [2:0] bar_s;
   logic       show_s;

   // Decode the bar index and blank the colour outside visible video
   always_comb begin
      bar_s  = 3'(count_h / 10'd80);
      // Row check repeats the active qualifier so a bad active input can never
      // light pixels in the vertical blanking interval.
      show_s = active && (count_v < 10'(V_VIS));
      if (show_s) begin
         rgb.r = bar_s[2] ? 4'hF : 4'h0;
         rgb.g = bar_s[1] ? 4'hF : 4'h0;
         rgb.b = bar_s[0] ? 4'hF : 4'h0;
      end else begin
         rgb = rgb12_t'(12'h000);
      end
   end

endmodule

// File: rtl/vga_core.sv
// vga_core: free-running VGA timing generator with colour-bar test pattern.
// Counters sweep 800 x 525 pixel clocks; sync and colour are registered one
// clock behind the counters. Define VGA_SYNC_POSITIVE_EN for active-high
// sync pulses (idle and reset level 0); default is active-low sync.
module vga_core #(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK
) (
   input  logic clk,
   input  logic rst,
   output logic r0,
   output logic r1,
   output logic r2,
   output logic r3,
   output logic g0,
   output logic g1,
   output logic g2,
   output logic g3,
   output logic b0,
   output logic b1,
   output logic b2,
   output logic b3,
   output logic hs,
   output logic vs
);

   localparam int W = vga_pkg::CNT_W;

   localparam logic [W-1:0] H_VIS_L  = W'(H_VISIBLE);
   localparam logic [W-1:0] HS_START = W'(H_VISIBLE + H_FRONT);
   localparam logic [W-1:0] HS_END   = W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [W-1:0] H_LAST   = W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [W-1:0] V_VIS_L  = W'(V_VISIBLE);
   localparam logic [W-1:0] VS_START = W'(V_VISIBLE + V_FRONT);
   localparam logic [W-1:0] VS_END   = W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [W-1:0] V_LAST   = W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

`ifdef VGA_SYNC_POSITIVE_EN
   localparam logic SYNC_ON = 1'b1;
`else
   localparam logic SYNC_ON = 1'b0;
`endif
   localparam logic SYNC_IDLE = ~SYNC_ON;

   logic [W-1:0]    count_h_r;
   logic [W-1:0]    count_v_r;
   logic            active_s;
   logic            hs_on_s;
   logic            vs_on_s;
   vga_pkg::rgb12_t rgb_s;
   vga_pkg::rgb12_t rgb_r;
   logic            hs_r;
   logic            vs_r;

   // Pixel/line counters; any out-of-range value wraps to 0 on the next clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_h_r <= 10'd0;
         count_v_r <= 10'd0;
      end else if (count_h_r >= H_LAST) begin
         count_h_r <= 10'd0;
         count_v_r <= (count_v_r >= V_LAST) ? 10'd0 : count_v_r + 10'd1;
      end else begin
         count_h_r <= count_h_r + 10'd1;
         count_v_r <= (count_v_r > V_LAST) ? 10'd0 : count_v_r;
      end
   end

   // Decode active video and sync windows from the current counter values
   always_comb begin
      active_s = (count_h_r < H_VIS_L) && (count_v_r < V_VIS_L);
      hs_on_s  = (count_h_r >= HS_START) && (count_h_r <= HS_END);
      vs_on_s  = (count_v_r >= VS_START) && (count_v_r <= VS_END);
   end

   vga_pattern #(
      .V_VIS   (V_VISIBLE)
   ) u_pattern (
      .count_h (count_h_r),
      .count_v (count_v_r),
      .active  (active_s),
      .rgb     (rgb_s)
   );

   // Output registers: colour and sync lag the counters by one clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_r <= vga_pkg::rgb12_t'(12'h000);
         hs_r  <= SYNC_IDLE;
         vs_r  <= SYNC_IDLE;
      end else begin
         rgb_r <= rgb_s;
         hs_r  <= hs_on_s ? SYNC_ON : SYNC_IDLE;
         vs_r  <= vs_on_s ? SYNC_ON : SYNC_IDLE;
      end
   end

   assign r0 = rgb_r.r[0];
   assign r1 = rgb_r.r[1];
   assign r2 = rgb_r.r[2];
   assign r3 = rgb_r.r[3];
   assign g0 = rgb_r.g[0];
   assign g1 = rgb_r.g[1];
   assign g2 = rgb_r.g[2];
   assign g3 = rgb_r.g[3];
   assign b0 = rgb_r.b[0];
   assign b1 = rgb_r.b[1];
   assign b2 = rgb_r.b[2];
   assign b3 = rgb_r.b[3];
   assign hs = hs_r;
   assign vs = vs_r;

endmodule

// File: tb/tb_vga_core.sv
// tb_vga_core: self-checking bench for vga_core. A full-size instance checks
// reset, horizontal timing, colour bars and mid-frame reset; a second instance
// with a 10-line frame checks vertical blanking, vsync width and frame period
// within a short run. Expected pixels come from the cycle count since reset.
module tb_vga_core;

`ifdef VGA_SYNC_POSITIVE_EN
   localparam logic SON = 1'b1;
`else
   localparam logic SON = 1'b0;
`endif
   localparam logic SIDLE = ~SON;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [3:0] r, g, b;
   logic hs, vs;
   logic [3:0] rv, gv, bv;
   logic hsv, vsv;

   int          compared = 0;
   int          mismatched = 0;
   int unsigned cyc = 0;
   logic [13:0] sb[$];

   always #5 clk = ~clk;

   vga_core dut (
      .clk(clk), .rst(rst),
      .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
      .g0(g[0]), .g1(g[1]), .g2(g[2]), .g3(g[3]),
      .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
      .hs(hs), .vs(vs)
   );

   vga_core #(
      .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) dut_small (
      .clk(clk), .rst(rst),
      .r0(rv[0]), .r1(rv[1]), .r2(rv[2]), .r3(rv[3]),
      .g0(gv[0]), .g1(gv[1]), .g2(gv[2]), .g3(gv[3]),
      .b0(bv[0]), .b1(bv[1]), .b2(bv[2]), .b3(bv[3]),
      .hs(hsv), .vs(vsv)
   );

   // Expected {rgb, hs, vs} for the pixel whose counters are (h, v)
   function automatic logic [13:0] pixel_exp(int h, int v, int v_vis, int vs_lo, int vs_hi);
      logic [2:0]  bar;
      logic [11:0] c;
      logic        hl, vl;
      c = 12'h000;
      if (h < 640 && v < v_vis) begin
         bar = 3'(h / 80);
         c = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      end
      hl = (h >= 656 && h <= 751) ? SON : SIDLE;
      vl = (v >= vs_lo && v <= vs_hi) ? SON : SIDLE;
      return {c, hl, vl};
   endfunction

   function automatic logic [13:0] out_main();
      return {r, g, b, hs, vs};
   endfunction

   function automatic logic [13:0] out_small();
      return {rv, gv, bv, hsv, vsv};
   endfunction

   function automatic int cur_h();
      return int'(cyc % 800);
   endfunction

   function automatic int cur_v();
      return int'((cyc / 800) % 525);
   endfunction

   function automatic int cur_v_small();
      return int'((cyc / 800) % 10);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rst) cyc++;
   endtask

   task automatic test_reset();
      logic [13:0] e;
      rst = 1'b0;
      repeat (5) step();
      cyc = 0;
      compared++;
      if (out_main() !== {12'h000, SIDLE, SIDLE}) begin
         mismatched++;
         $display("FAIL reset_out got=%h exp=%h", out_main(), {12'h000, SIDLE, SIDLE});
      end
      compared++;
      if (out_small() !== {12'h000, SIDLE, SIDLE}) begin
         mismatched++;
         $display("FAIL reset_out_small got=%h exp=%h", out_small(), {12'h000, SIDLE, SIDLE});
      end
      compared++;
      if (dut.count_h_r !== 10'd0 || dut.count_v_r !== 10'd0) begin
         mismatched++;
         $display("FAIL reset_counters got=%0d,%0d exp=0,0", dut.count_h_r, dut.count_v_r);
      end
      sb.push_back(pixel_exp(0, 0, 480, 490, 491));
      rst = 1'b1;
      step();
      e = sb.pop_front();
      compared++;
      if (out_main() !== e) begin
         mismatched++;
         $display("FAIL first_pixel got=%h exp=%h", out_main(), e);
      end
      compared++;
      if (dut.count_h_r !== 10'd1 || dut.count_v_r !== 10'd0) begin
         mismatched++;
         $display("FAIL release_count got=%0d,%0d exp=1,0", dut.count_h_r, dut.count_v_r);
      end
   endtask

   task automatic test_hsync();
      int   fall1 = -1;
      int   fall2 = -1;
      int   width = 0;
      logic prev;
      prev = hs;
      for (int i = 0; i < 1700; i++) begin
         step();
         if (prev !== SON && hs === SON) begin
            if (fall1 < 0) fall1 = int'(cyc);
            else if (fall2 < 0) fall2 = int'(cyc);
         end
         if (hs === SON && fall1 >= 0 && fall2 < 0) width++;
         prev = hs;
      end
      compared++;
      if (fall1 != 657) begin
         mismatched++;
         $display("FAIL hsync_start got=%0d exp=657", fall1);
      end
      compared++;
      if (width != 96) begin
         mismatched++;
         $display("FAIL hsync_width got=%0d exp=96", width);
      end
      compared++;
      if (fall2 - fall1 != 800) begin
         mismatched++;
         $display("FAIL hsync_period got=%0d exp=800", fall2 - fall1);
      end
   endtask

   task automatic test_pattern();
      int          targets[8] = '{0, 79, 80, 160, 400, 639, 640, 700};
      logic [13:0] e;
      int          guard;
      foreach (targets[k]) begin
         guard = 0;
         while (cur_h() != targets[k] && guard < 900) begin
            step();
            guard++;
         end
         sb.push_back(pixel_exp(targets[k], cur_v(), 480, 490, 491));
         step();
         e = sb.pop_front();
         compared++;
         if (guard >= 900 || out_main() !== e) begin
            mismatched++;
            $display("FAIL pattern h=%0d got=%h exp=%h", targets[k], out_main(), e);
         end
      end
   endtask

   task automatic test_vblank();
      int          th[4] = '{639, 100, 639, 0};
      int          tv[4] = '{3, 4, 7, 9};
      logic [13:0] e;
      int          guard;
      for (int k = 0; k < 4; k++) begin
         guard = 0;
         while ((cur_h() != th[k] || cur_v_small() != tv[k]) && guard < 9000) begin
            step();
            guard++;
         end
         sb.push_back(pixel_exp(th[k], tv[k], 4, 6, 7));
         step();
         e = sb.pop_front();
         compared++;
         if (guard >= 9000 || out_small() !== e) begin
            mismatched++;
            $display("FAIL vblank h=%0d v=%0d got=%h exp=%h", th[k], tv[k], out_small(), e);
         end
      end
   endtask

   task automatic test_vsync();
      int   fall1 = -1;
      int   fall2 = -1;
      int   width = 0;
      int   main_vs_on = 0;
      logic prev;
      prev = vsv;
      for (int i = 0; i < 17000; i++) begin
         step();
         if (prev !== SON && vsv === SON) begin
            if (fall1 < 0) fall1 = int'(cyc);
            else if (fall2 < 0) fall2 = int'(cyc);
         end
         if (vsv === SON && fall1 >= 0 && fall2 < 0) width++;
         if (vs !== SIDLE) main_vs_on++;
         prev = vsv;
      end
      compared++;
      if (fall1 < 0 || (fall1 % 8000) != 4801) begin
         mismatched++;
         $display("FAIL vsync_start got=%0d exp=4801 mod 8000", fall1);
      end
      compared++;
      if (width != 1600) begin
         mismatched++;
         $display("FAIL vsync_width got=%0d exp=1600", width);
      end
      compared++;
      if (fall2 - fall1 != 8000) begin
         mismatched++;
         $display("FAIL frame_period got=%0d exp=8000", fall2 - fall1);
      end
      compared++;
      if (main_vs_on != 0) begin
         mismatched++;
         $display("FAIL vs_idle_main got=%0d exp=0", main_vs_on);
      end
   endtask

   task automatic test_midframe_reset();
      logic [13:0] e;
      int          guard = 0;
      while (cur_h() != 300 && guard < 900) begin
         step();
         guard++;
      end
      #2;
      rst = 1'b0;
      #1;
      compared++;
      if (guard >= 900 || out_main() !== {12'h000, SIDLE, SIDLE} ||
          out_small() !== {12'h000, SIDLE, SIDLE}) begin
         mismatched++;
         $display("FAIL async_reset_out got=%h exp=%h", out_main(), {12'h000, SIDLE, SIDLE});
      end
      compared++;
      if (dut.count_h_r !== 10'd0 || dut.count_v_r !== 10'd0) begin
         mismatched++;
         $display("FAIL async_reset_count got=%0d,%0d exp=0,0", dut.count_h_r, dut.count_v_r);
      end
      repeat (3) step();
      cyc = 0;
      rst = 1'b1;
      sb.push_back(pixel_exp(0, 0, 480, 490, 491));
      step();
      e = sb.pop_front();
      compared++;
      if (out_main() !== e || dut.count_h_r !== 10'd1) begin
         mismatched++;
         $display("FAIL restart_pixel got=%h/%0d exp=%h/1", out_main(), dut.count_h_r, e);
      end
      while (cur_h() != 80) step();
      sb.push_back(pixel_exp(80, 0, 480, 490, 491));
      step();
      e = sb.pop_front();
      compared++;
      if (out_main() !== e) begin
         mismatched++;
         $display("FAIL restart_blue got=%h exp=%h", out_main(), e);
      end
   endtask

   initial begin
      test_reset();
      test_hsync();
      test_pattern();
      test_vblank();
      test_vsync();
      test_midframe_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
